// File: rtl/fpu_issue_seq.sv
// fpu_issue_seq: issue-side sequencer for the FPU.
// Takes one op at a time from decode, holds BusA/BusB/FPUCtrl for the op's
// fixed latency, captures BusO and presents it to FP writeback.
// Optional feature: define FPU_SEQ_FLUSH_EN to add a synchronous Flush input.
module fpu_issue_seq #(
  parameter int ADD_LAT  = 2,
  parameter int MUL_LAT  = 4,
  parameter int DIV_LAT  = 10,
  parameter int DP_EXTRA = 2
) (
  input  logic        CLK,
  input  logic        Reset_L,
`ifdef FPU_SEQ_FLUSH_EN
  input  logic        Flush,
`endif
  input  logic        IssueValid,
  output logic        IssueReady,
  input  logic [3:0]  IssueOp,
  input  logic [63:0] IssueA,
  input  logic [63:0] IssueB,
  input  logic [4:0]  IssueTag,
  output logic [63:0] BusA,
  output logic [63:0] BusB,
  output logic [3:0]  FPUCtrl,
  input  logic [63:0] BusO,
  output logic        WbValid,
  input  logic        WbReady,
  output logic [63:0] WbData,
  output logic [4:0]  WbTag,
  output logic        WbErr,
  output logic        Busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] bus_a_q, bus_a_d, bus_b_q, bus_b_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [63:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_tag_q, wb_tag_d;
  logic        wb_err_q, wb_err_d;
  logic        flush;
  logic [4:0]  lat;

`ifdef FPU_SEQ_FLUSH_EN
  assign flush = Flush;
`else
  assign flush = 1'b0;
`endif

  // Total latency of the op being presented: base by class, plus DP penalty.
  always_comb begin
    lat = 5'(ADD_LAT);
    case (IssueOp[1:0])
      2'b10:   lat = 5'(MUL_LAT);
      2'b11:   lat = 5'(DIV_LAT);
      default: lat = 5'(ADD_LAT);
    endcase
    if (IssueOp[2]) lat = lat + 5'(DP_EXTRA);
  end

  // Next-state and datapath load decisions.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bus_a_d   = bus_a_q;
    bus_b_d   = bus_b_q;
    ctrl_d    = ctrl_q;
    wb_data_d = wb_data_q;
    wb_tag_d  = wb_tag_q;
    wb_err_d  = wb_err_q;
    case (state_q)
      S_IDLE: begin
        if (IssueValid && !flush) begin
          wb_tag_d = IssueTag;
          if (IssueOp[3]) begin
            // Illegal op: no FPU activity, report error straight away.
            wb_data_d = 64'h0;
            wb_err_d  = 1'b1;
            state_d   = S_DONE;
          end else begin
            bus_a_d = IssueA;
            bus_b_d = IssueB;
            ctrl_d  = IssueOp;
            cnt_d   = lat - 5'd1;
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (flush) begin
          cnt_d   = 5'd0;
          state_d = S_IDLE;
        end else if (cnt_q == 5'd0) begin
          wb_data_d = ctrl_q[2] ? BusO : {32'h0, BusO[31:0]};
          wb_err_d  = 1'b0;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_DONE: begin
        if (flush || WbReady) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight op.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      bus_a_q   <= 64'h0;
      bus_b_q   <= 64'h0;
      ctrl_q    <= 4'b0000;
      wb_data_q <= 64'h0;
      wb_tag_q  <= 5'd0;
      wb_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_a_q   <= bus_a_d;
      bus_b_q   <= bus_b_d;
      ctrl_q    <= ctrl_d;
      wb_data_q <= wb_data_d;
      wb_tag_q  <= wb_tag_d;
      wb_err_q  <= wb_err_d;
    end
  end

  assign IssueReady = (state_q == S_IDLE) && !flush;
  assign Busy       = (state_q != S_IDLE);
  assign WbValid    = (state_q == S_DONE);
  assign BusA       = bus_a_q;
  assign BusB       = bus_b_q;
  assign FPUCtrl    = ctrl_q;
  assign WbData     = wb_data_q;
  assign WbTag      = wb_tag_q;
  assign WbErr      = wb_err_q;

endmodule

// File: tb/tb_fpu_issue_seq.sv
// Directed bench for fpu_issue_seq. Inputs driven and outputs sampled on the
// falling edge; idx k below means "k rising edges after the accept edge".
module tb_fpu_issue_seq;
  logic        CLK = 1'b0;
  logic        Reset_L;
  logic        Flush;
  logic        IssueValid;
  logic        IssueReady;
  logic [3:0]  IssueOp;
  logic [63:0] IssueA, IssueB;
  logic [4:0]  IssueTag;
  logic [63:0] BusA, BusB;
  logic [3:0]  FPUCtrl;
  logic [63:0] BusO;
  logic        WbValid, WbReady;
  logic [63:0] WbData;
  logic [4:0]  WbTag;
  logic        WbErr, Busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  fpu_issue_seq dut (
    .CLK(CLK), .Reset_L(Reset_L),
`ifdef FPU_SEQ_FLUSH_EN
    .Flush(Flush),
`endif
    .IssueValid(IssueValid), .IssueReady(IssueReady), .IssueOp(IssueOp),
    .IssueA(IssueA), .IssueB(IssueB), .IssueTag(IssueTag),
    .BusA(BusA), .BusB(BusB), .FPUCtrl(FPUCtrl), .BusO(BusO),
    .WbValid(WbValid), .WbReady(WbReady), .WbData(WbData), .WbTag(WbTag),
    .WbErr(WbErr), .Busy(Busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] tag);
    IssueValid = 1'b1; IssueOp = op; IssueA = a; IssueB = b; IssueTag = tag;
  endtask

  logic saw_wb;

  initial begin
    Reset_L = 1'b0; Flush = 1'b0; IssueValid = 1'b0; IssueOp = 4'h0;
    IssueA = '0; IssueB = '0; IssueTag = '0; BusO = '0; WbReady = 1'b1;
    @(negedge CLK);
    // Reset state
    chk("rst_busa", BusA, 64'h0);
    chk("rst_ctrl", {60'h0, FPUCtrl}, 64'h0);
    chk("rst_wbvalid", {63'h0, WbValid}, 64'h0);
    chk("rst_wbdata", WbData, 64'h0);
    chk("rst_busy", {63'h0, Busy}, 64'h0);
    Reset_L = 1'b1;
    tick();
    chk("rst_ready", {63'h0, IssueReady}, 64'h1);

    // ADD32: L=2, upper half of BusO dropped
    BusO = 64'hDEAD_BEEF_4040_0000;
    issue(4'b0000, 64'h3F80_0000, 64'h4000_0000, 5'd3);
    tick();                                  // idx0
    IssueValid = 1'b0;
    chk("add_busa", BusA, 64'h3F80_0000);
    chk("add_busb", BusB, 64'h4000_0000);
    chk("add_ready0", {63'h0, IssueReady}, 64'h0);
    tick();                                  // idx1
    chk("add_wbv1", {63'h0, WbValid}, 64'h0);
    tick();                                  // idx2
    chk("add_wbv2", {63'h0, WbValid}, 64'h1);
    chk("add_data", WbData, 64'h0000_0000_4040_0000);
    chk("add_tag", {59'h0, WbTag}, 64'd3);
    chk("add_err", {63'h0, WbErr}, 64'h0);
    tick();                                  // idx3: handshake done
    chk("add_ready3", {63'h0, IssueReady}, 64'h1);
    chk("add_wbv3", {63'h0, WbValid}, 64'h0);

    // MUL64: L=6, writeback stalled
    WbReady = 1'b0;
    BusO = 64'h1122_3344_5566_7788;
    issue(4'b0110, 64'hAAAA, 64'hBBBB, 5'd12);
    tick();                                  // idx0
    IssueValid = 1'b0;
    chk("mul_ctrl", {60'h0, FPUCtrl}, 64'h6);
    repeat (5) tick();                       // idx5
    chk("mul_wbv5", {63'h0, WbValid}, 64'h0);
    tick();                                  // idx6
    chk("mul_wbv6", {63'h0, WbValid}, 64'h1);
    BusO = 64'hFFFF_0000_FFFF_0000;
    repeat (4) tick();                       // idx10, still stalled
    chk("mul_data", WbData, 64'h1122_3344_5566_7788);
    chk("mul_tag", {59'h0, WbTag}, 64'd12);
    chk("mul_ready_stall", {63'h0, IssueReady}, 64'h0);
    WbReady = 1'b1;
    tick();                                  // idx11
    chk("mul_ready_after", {63'h0, IssueReady}, 64'h1);

    // DIV32 then ADD32 held valid: L=10
    BusO = 64'h5555_6666_7777_8888;
    issue(4'b0011, 64'hC0FFEE, 64'h2, 5'd9);
    tick();                                  // idx0
    issue(4'b0000, 64'h1234, 64'h5678, 5'd4);
    for (int i = 0; i <= 10; i++) begin
      chk("div_busa", BusA, 64'hC0FFEE);
      chk("div_ctrl", {60'h0, FPUCtrl}, 64'h3);
      if (i == 9)  chk("div_wbv9", {63'h0, WbValid}, 64'h0);
      if (i == 10) chk("div_wbv10", {63'h0, WbValid}, 64'h1);
      if (i < 10) tick();
    end
    chk("div_data", WbData, 64'h0000_0000_7777_8888);
    chk("div_ready10", {63'h0, IssueReady}, 64'h0);
    tick();                                  // idx11: second op accepted at next edge
    chk("div_ready11", {63'h0, IssueReady}, 64'h1);
    tick();                                  // idx12
    IssueValid = 1'b0;
    chk("b2b_ctrl", {60'h0, FPUCtrl}, 64'h0);
    chk("b2b_busa", BusA, 64'h1234);
    tick(); tick();
    chk("b2b_wbv", {63'h0, WbValid}, 64'h1);
    chk("b2b_tag", {59'h0, WbTag}, 64'd4);
    tick();

    // Illegal op: immediate error writeback, FPU buses untouched
    issue(4'b1010, 64'hDEAD, 64'hBEEF, 5'd7);
    tick();
    IssueValid = 1'b0;
    chk("ill_wbv", {63'h0, WbValid}, 64'h1);
    chk("ill_err", {63'h0, WbErr}, 64'h1);
    chk("ill_data", WbData, 64'h0);
    chk("ill_tag", {59'h0, WbTag}, 64'd7);
    chk("ill_ctrl", {60'h0, FPUCtrl}, 64'h0);
    chk("ill_busa", BusA, 64'h1234);
    tick();
    chk("ill_ready", {63'h0, IssueReady}, 64'h1);

    // Reset in the middle of DIV64
    issue(4'b0111, 64'h77, 64'h88, 5'd21);
    tick();
    IssueValid = 1'b0;
    repeat (3) tick();
    chk("rdiv_busy", {63'h0, Busy}, 64'h1);
    Reset_L = 1'b0;
    #1;
    chk("rdiv_busa", BusA, 64'h0);
    chk("rdiv_ctrl", {60'h0, FPUCtrl}, 64'h0);
    chk("rdiv_tag", {59'h0, WbTag}, 64'h0);
    chk("rdiv_busy0", {63'h0, Busy}, 64'h0);
    @(negedge CLK);
    Reset_L = 1'b1;
    tick();
    chk("rdiv_ready", {63'h0, IssueReady}, 64'h1);
    saw_wb = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (WbValid) saw_wb = 1'b1;
    end
    chk("rdiv_no_wb", {63'h0, saw_wb}, 64'h0);

`ifdef FPU_SEQ_FLUSH_EN
    // MUL32 (L=4) flushed on the completion edge
    issue(4'b0010, 64'h10, 64'h20, 5'd2);
    tick();                                  // idx0
    IssueValid = 1'b0;
    repeat (3) tick();                       // idx3
    Flush = 1'b1;
    tick();                                  // idx4
    Flush = 1'b0;
    chk("fl_busy", {63'h0, Busy}, 64'h0);
    chk("fl_wbv", {63'h0, WbValid}, 64'h0);
    // Flush in IDLE blocks acceptance
    Flush = 1'b1;
    issue(4'b0100, 64'h30, 64'h40, 5'd6);
    #1;
    chk("fl_ready", {63'h0, IssueReady}, 64'h0);
    tick();
    chk("fl_idle_busy", {63'h0, Busy}, 64'h0);
    Flush = 1'b0;
    tick();                                  // ADD64 accepted, idx0
    IssueValid = 1'b0;
    repeat (4) tick();                       // idx4
    chk("fl_add_wbv", {63'h0, WbValid}, 64'h1);
    chk("fl_add_tag", {59'h0, WbTag}, 64'd6);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
